note_recorder: RTL



---
 rtl/note_recorder_if.sv | 28 ++
 rtl/note_recorder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/note_recorder_if.sv
// Recorder bus: key levels and controller pulses in, packed level word, length and status out.
// Latency: none, wiring only.
// Backpressure: none. Pulses are single-cycle and the outputs are level/pulse signals.
interface note_recorder_if #(
    parameter int MAX_NOTES = 4,
    parameter int NOTE_W    = 4
);
    logic [NOTE_W-1:0]           note_inputs;
    logic                        start_record;
    logic                        stop_record;
    logic [MAX_NOTES*NOTE_W-1:0] level_data;
    logic [3:0]                  level_length;
    logic                        recording;
    logic                        done_record;
    logic [NOTE_W-1:0]           note_echo;

    // Controller / key side
    modport master (
        output note_inputs, start_record, stop_record,
        input  level_data, level_length, recording, done_record, note_echo
    );

    // Recorder side
    modport slave (
        input  note_inputs, start_record, stop_record,
        output level_data, level_length, recording, done_record, note_echo
    );
endinterface

// File: rtl/note_recorder.sv
// Compose-mode recorder: debounces key presses and packs them MSB-first into a level word and a length.
// Latency: press to commit is 2 sync + DEBOUNCE_CYCLES + hold time + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none. Optional idle auto-finish is enabled with macro RECORD_TIMEOUT_EN.
module note_recorder #(
    parameter int MAX_NOTES       = 4,
    parameter int NOTE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES  = 100000000
) (
    input  logic            clk,
    input  logic            resetn,
    note_recorder_if.slave  rec
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [3:0] LAST_IDX = 4'(MAX_NOTES - 1);

    // Reject illegal configurations at elaboration.
    if (MAX_NOTES < 1 || MAX_NOTES > 15) begin : g_bad_max_notes
        $error("note_recorder: MAX_NOTES must be in 1..15");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("note_recorder: DEBOUNCE_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("note_recorder: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RELEASE,
        S_WAIT_PRESS,
        S_HOLD,
        S_FINISH
    } state_t;

    state_t                      state;
    logic [NOTE_W-1:0]           sync_q1;
    logic [NOTE_W-1:0]           sync_q2;
    logic [NOTE_W-1:0]           db_val;
    logic [DB_W-1:0]             db_cnt;
    logic [DB_W-1:0]             db_next;
    logic                        stable;
    logic                        stable_zero;
    logic                        stable_press;
    logic                        timeout_hit;
    logic [NOTE_W-1:0]           pending;
    logic [NOTE_W-1:0]           note_echo_q;
    logic [MAX_NOTES*NOTE_W-1:0] level_data_q;
    logic [3:0]                  level_length_q;
    logic                        recording_q;
    logic                        done_q;

    // Two-flop synchroniser for the asynchronous key levels.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= rec.note_inputs;
            sync_q2 <= sync_q1;
        end
    end

    // Run length of the current synchronised value, saturating at DEBOUNCE_CYCLES.
    always_comb begin
        db_next = DB_W'(1);
        if (sync_q2 == db_val) begin
            db_next = (db_cnt == DB_MAX) ? DB_MAX : db_cnt + 1'b1;
        end
    end

    assign stable       = (db_next == DB_MAX);
    assign stable_zero  = stable && (sync_q2 == '0);
    assign stable_press = stable && (sync_q2 != '0);

    // Debounce tracking; note_echo follows the last value that stayed stable long enough.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            db_val      <= '0;
            db_cnt      <= '0;
            note_echo_q <= '0;
        end else begin
            db_val <= sync_q2;
            db_cnt <= db_next;
            if (stable) begin
                note_echo_q <= sync_q2;
            end
        end
    end

`ifdef RECORD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // Idle counter: only advances while waiting for a press with at least one note stored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt <= '0;
        end else if (state != S_WAIT_PRESS || sync_q2 != '0) begin
            to_cnt <= '0;
        end else if (level_length_q != '0) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_WAIT_PRESS) && (level_length_q != '0) &&
                         (sync_q2 == '0) && (to_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Recording FSM with registered status outputs and the packed level word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            pending        <= '0;
            level_data_q   <= '0;
            level_length_q <= '0;
            recording_q    <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rec.start_record) begin
                        level_data_q   <= '0;
                        level_length_q <= '0;
                        recording_q    <= 1'b1;
                        state          <= S_WAIT_RELEASE;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (rec.stop_record) begin
                        state       <= S_FINISH;
                        recording_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (stable_zero) begin
                        state <= S_WAIT_PRESS;
                    end
                end
                S_WAIT_PRESS: begin
                    // A partially debounced press is simply dropped on stop or timeout.
                    if (rec.stop_record || timeout_hit) begin
                        state       <= S_FINISH;
                        recording_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (stable_press) begin
                        pending <= sync_q2;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // An accepted note is committed on release, or immediately on stop.
                    if (rec.stop_record || stable_zero) begin
                        for (int i = 0; i < MAX_NOTES; i++) begin
                            if (level_length_q == 4'(i)) begin
                                level_data_q[(MAX_NOTES-1-i)*NOTE_W +: NOTE_W] <= pending;
                            end
                        end
                        level_length_q <= level_length_q + 4'd1;
                        if (rec.stop_record || level_length_q == LAST_IDX) begin
                            state       <= S_FINISH;
                            recording_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state <= S_WAIT_PRESS;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    recording_q <= 1'b0;
                end
            endcase
        end
    end

    assign rec.level_data   = level_data_q;
    assign rec.level_length = level_length_q;
    assign rec.recording    = recording_q;
    assign rec.done_record  = done_q;
    assign rec.note_echo    = note_echo_q;

endmodule
